defuzzifier: RTL

Sequential defuzzification stage that sits directly downstream of the rule engine in the irrigation fuzzy controller. It takes the three aggregated output memberships (irrigar_pouco, irrigar_medio, irrigar_muito) and produces one crisp 8-bit irrigation duty value. The value is the weighted average of three singleton centres, computed with a multi-cycle restoring divider. A valid/ready handshake on both sides lets the rule engine's combinational outputs be sampled once per decision and the result be consumed by the pump/PWM stage.

---
 rtl/fuzzy_pkg.sv | 20 ++
 rtl/seq_divider.sv | 55 +++++
 rtl/defuzzifier.sv | 106 ++++++++++
 3 files changed

// File: rtl/fuzzy_pkg.sv
// Shared types and constants for the irrigation fuzzy controller datapath.
package fuzzy_pkg;

  localparam int MU_W  = 8;
  localparam int NUM_W = 18;
  localparam int DEN_W = 10;
  localparam int CNT_W = 5;

  localparam int C_POUCO_DEF = 40;
  localparam int C_MEDIO_DEF = 128;
  localparam int C_MUITO_DEF = 230;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_DIV,
    S_DONE
  } defuzz_state_t;

endpackage

// File: rtl/seq_divider.sv
// Unsigned restoring divider, NUM_W-bit dividend by DEN_W-bit divisor, one
// quotient bit per cycle, MSB first.
module seq_divider
  import fuzzy_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [NUM_W-1:0] dividend,
  input  logic [DEN_W-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [NUM_W-1:0] quotient
);

  // Dividend bits shift out of the top while quotient bits shift in at the bottom.
  logic [NUM_W-1:0] shift_q;
  logic [DEN_W:0]   rem_q;
  logic [DEN_W-1:0] den_q;
  logic [CNT_W-1:0] cnt_q;

  logic [DEN_W:0]   rem_sh;
  logic [DEN_W:0]   rem_n;
  logic             ge;

  always_comb begin
    rem_sh   = {rem_q[DEN_W-1:0], shift_q[NUM_W-1]};
    ge       = ({rem_q, shift_q[NUM_W-1]} >= {2'b00, den_q});
    rem_n    = ge ? (rem_sh - {1'b0, den_q}) : rem_sh;
    quotient = {shift_q[NUM_W-2:0], ge};
    done     = busy && (cnt_q == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q <= '0;
      rem_q   <= '0;
      den_q   <= '0;
      cnt_q   <= '0;
      busy    <= 1'b0;
    end else if (start) begin
      shift_q <= dividend;
      rem_q   <= '0;
      den_q   <= divisor;
      cnt_q   <= CNT_W'(NUM_W - 1);
      busy    <= 1'b1;
    end else if (busy) begin
      shift_q <= quotient;
      rem_q   <= rem_n;
      cnt_q   <= cnt_q - 1'b1;
      if (cnt_q == '0) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/defuzzifier.sv
// Weighted-average defuzzifier: three singleton centres, crisp 8-bit duty out,
// valid/ready on both sides.
//
// state | meaning
// IDLE  | in_ready high, waiting for memberships
// LOAD  | numerator/denominator formed, divider started unless den is zero
// DIV   | divider iterating (or one bypass cycle for the all-zero case)
// DONE  | out_valid high, result held until out_ready
module defuzzifier
  import fuzzy_pkg::*;
#(
  parameter int C_POUCO        = C_POUCO_DEF,
  parameter int C_MEDIO        = C_MEDIO_DEF,
  parameter int C_MUITO        = C_MUITO_DEF,
  parameter int DUTY_SEM_REGRA = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [MU_W-1:0] irrigar_pouco,
  input  logic [MU_W-1:0] irrigar_medio,
  input  logic [MU_W-1:0] irrigar_muito,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [MU_W-1:0] duty,
  output logic            sem_regra
);

  localparam logic [NUM_W-1:0] CP = NUM_W'(C_POUCO);
  localparam logic [NUM_W-1:0] CM = NUM_W'(C_MEDIO);
  localparam logic [NUM_W-1:0] CU = NUM_W'(C_MUITO);

  defuzz_state_t    state;
  logic [MU_W-1:0]  p_q, m_q, u_q;
  logic [NUM_W-1:0] num;
  logic [DEN_W-1:0] den;
  logic             div_start, div_busy, div_done;
  logic [NUM_W-1:0] div_quot;

  always_comb begin
    num       = NUM_W'(p_q) * CP + NUM_W'(m_q) * CM + NUM_W'(u_q) * CU;
    den       = DEN_W'(p_q) + DEN_W'(m_q) + DEN_W'(u_q);
    div_start = (state == S_LOAD) && (den != '0);
  end

  seq_divider u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (div_start),
    .dividend (num),
    .divisor  (den),
    .busy     (div_busy),
    .done     (div_done),
    .quotient (div_quot)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      duty      <= '0;
      sem_regra <= 1'b0;
      p_q       <= '0;
      m_q       <= '0;
      u_q       <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            p_q      <= irrigar_pouco;
            m_q      <= irrigar_medio;
            u_q      <= irrigar_muito;
            in_ready <= 1'b0;
            state    <= S_LOAD;
          end
        end
        S_LOAD: state <= S_DIV;
        S_DIV: begin
          // Divider never started means the denominator was zero.
          if (!div_busy) begin
            duty      <= MU_W'(DUTY_SEM_REGRA);
            sem_regra <= 1'b1;
            out_valid <= 1'b1;
            state     <= S_DONE;
          end else if (div_done) begin
            duty      <= (|div_quot[NUM_W-1:MU_W]) ? '1 : div_quot[MU_W-1:0];
            sem_regra <= 1'b0;
            out_valid <= 1'b1;
            state     <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
